// File: rtl/tiny_pkg.sv
// Shared encodings for the Tiny sequencer core: addressing modes, opcodes,
// FSM states and flag bit positions.
package tiny_pkg;

    localparam logic [1:0] MODE_IMM = 2'd0;
    localparam logic [1:0] MODE_ABS = 2'd1;
    localparam logic [1:0] MODE_OFF = 2'd2;
    localparam logic [1:0] MODE_REG = 2'd3;

    localparam logic [5:0] OP_LOAD  = 6'h01;
    localparam logic [5:0] OP_STORE = 6'h02;
    localparam logic [5:0] OP_JMP   = 6'h04;
    localparam logic [5:0] OP_JZ    = 6'h05;
    localparam logic [5:0] OP_JC    = 6'h06;
    localparam logic [5:0] OP_JN    = 6'h07;
    localparam logic [5:0] OP_ADD   = 6'h08;
    localparam logic [5:0] OP_ADC   = 6'h09;
    localparam logic [5:0] OP_SBB   = 6'h0A;
    localparam logic [5:0] OP_SUB   = 6'h0B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // flags register layout is {V,Z,N,C}
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 3;

    typedef enum logic [2:0] {
        ST_FETCH_OP,
        ST_FETCH_ARG,
        ST_EXEC_RD,
        ST_EXEC_WR,
        ST_HALTED
    } state_t;

    function automatic logic is_jump(input logic [5:0] op);
        return op inside {OP_JMP, OP_JZ, OP_JC, OP_JN};
    endfunction

    function automatic logic is_known(input logic [5:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_JMP, OP_JZ, OP_JC, OP_JN,
                          OP_ADD, OP_ADC, OP_SBB, OP_SUB, OP_HALT};
    endfunction

endpackage

// File: rtl/tiny_alu.sv
// Combinational datapath: LOAD pass-through and the carry-chained add/subtract
// family, with NZCV outputs.
module tiny_alu
    import tiny_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             v,
    output logic             n,
    output logic             z
);

    logic [WIDTH-1:0] b_eff;
    logic             carry_in;
    logic [WIDTH:0]   sum;

    always_comb begin
        b_eff    = b;
        carry_in = 1'b0;
        case (op)
            OP_ADC: carry_in = cin;
            OP_SUB: begin
                b_eff    = ~b;
                carry_in = 1'b1;
            end
            OP_SBB: begin
                b_eff    = ~b;
                carry_in = cin;
            end
            default: ;
        endcase

        sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
        result = (op == OP_LOAD) ? b : sum[WIDTH-1:0];
        c      = sum[WIDTH];
        // overflow is judged on the operands actually summed, i.e. ~b for subtraction
        v      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        n      = result[WIDTH-1];
        z      = (result == '0);
    end

endmodule

// File: rtl/tiny_seq_core.sv
// Tiny accumulator machine: two-word fetch/execute FSM over a req/ack memory
// port, with PC-relative addressing, NZCV flags, HALT and illegal trapping.
module tiny_seq_core
    import tiny_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] acc,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] pc,
    output logic             halted,
    output logic             illegal
);

    state_t           state;
    logic [7:0]       ir;
    logic [1:0]       mode;
    logic [5:0]       opc;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] ea;
    logic             taken;
    logic             bad_instr;

    logic [WIDTH-1:0] alu_result;
    logic             alu_c, alu_v, alu_n, alu_z;
    logic [3:0]       exec_flags;

    assign mode = ir[7:6];
    assign opc  = ir[5:0];

    tiny_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (acc),
        .b      (mem_rdata),
        .op     (opc),
        .cin    (flags[FLAG_C]),
        .result (alu_result),
        .c      (alu_c),
        .v      (alu_v),
        .n      (alu_n),
        .z      (alu_z)
    );

    // B is always the word on mem_rdata: the operand itself for IMM, the EA data otherwise
    always_comb begin
        pc_inc    = pc + WIDTH'(1);
        ea        = (mode == MODE_OFF) ? pc_inc + mem_rdata : mem_rdata;
        bad_instr = !is_known(opc) || (mode == MODE_REG) ||
                    (opc == OP_STORE && mode == MODE_IMM);

        case (opc)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = flags[FLAG_Z];
            OP_JC:   taken = flags[FLAG_C];
            OP_JN:   taken = flags[FLAG_N];
            default: taken = 1'b0;
        endcase

        exec_flags         = {alu_v, alu_z, alu_n, alu_c};
        if (opc == OP_LOAD) begin
            exec_flags[FLAG_V] = flags[FLAG_V];
            exec_flags[FLAG_C] = flags[FLAG_C];
        end
    end

    // Completing a handshake sets up the next request on the same edge, so
    // zero-wait memory sustains one transfer per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_FETCH_OP;
            pc        <= RESET_PC;
            acc       <= '0;
            flags     <= '0;
            ir        <= '0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (run) begin
            case (state)
                ST_FETCH_OP: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        ir       <= mem_rdata[7:0];
                        pc       <= pc_inc;
                        mem_addr <= pc_inc;
                        state    <= ST_FETCH_ARG;
                    end
                end

                ST_FETCH_ARG: begin
                    if (mem_req && mem_ack) begin
                        pc <= pc_inc;
                        if (opc == OP_HALT) begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            halted  <= 1'b1;
                            state   <= ST_HALTED;
                        end else if (bad_instr) begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                            state   <= ST_HALTED;
                        end else if (is_jump(opc)) begin
                            pc       <= taken ? ea : pc_inc;
                            mem_addr <= taken ? ea : pc_inc;
                            state    <= ST_FETCH_OP;
                        end else if (mode == MODE_IMM) begin
                            acc      <= alu_result;
                            flags    <= exec_flags;
                            mem_addr <= pc_inc;
                            state    <= ST_FETCH_OP;
                        end else if (opc == OP_STORE) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= acc;
                            mem_addr  <= ea;
                            state     <= ST_EXEC_WR;
                        end else begin
                            mem_addr <= ea;
                            state    <= ST_EXEC_RD;
                        end
                    end
                end

                ST_EXEC_RD: begin
                    if (mem_req && mem_ack) begin
                        acc      <= alu_result;
                        flags    <= exec_flags;
                        mem_addr <= pc;
                        state    <= ST_FETCH_OP;
                    end
                end

                ST_EXEC_WR: begin
                    if (mem_req && mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        state    <= ST_FETCH_OP;
                    end
                end

                ST_HALTED: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end

                default: state <= ST_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny_seq_core.sv
// Bench for tiny_seq_core: directed programs plus random straight-line programs
// compared against an instruction-level reference model.
module tb_tiny_seq_core;

    localparam logic [15:0] RPC = 16'h0064;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b1;
    logic        run8 = 1'b0;

    logic        mem_req, mem_we, halted, illegal;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_addr, mem_wdata, acc, pc;
    logic [15:0] mem_rdata = '0;
    logic [3:0]  flags;

    logic        req8, we8, halted8, illegal8;
    logic        ack8 = 1'b0;
    logic [7:0]  addr8, wdata8, acc8, pc8;
    logic [7:0]  rdata8 = '0;
    logic [3:0]  flags8;

    always #5 clk = ~clk;

    tiny_seq_core #(.WIDTH(16), .RESET_PC(RPC)) u_dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .acc(acc), .flags(flags), .pc(pc), .halted(halted), .illegal(illegal)
    );

    tiny_seq_core #(.WIDTH(8), .RESET_PC(8'h00)) u_dut8 (
        .clk(clk), .reset(reset), .run(run8),
        .mem_req(req8), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8),
        .mem_rdata(rdata8), .mem_ack(ack8),
        .acc(acc8), .flags(flags8), .pc(pc8), .halted(halted8), .illegal(illegal8)
    );

    int unsigned checks = 0;
    int unsigned failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory with random wait states ----------------
    logic [15:0] mem  [0:65535];
    logic [15:0] rmem [0:65535];
    logic [7:0]  mem8 [0:255];
    int unsigned max_wait = 0;
    int unsigned wait_cnt = 0;
    bit          need_new = 1'b1;
    bit          completed = 1'b0;
    bit          prev_req = 1'b0;
    logic [15:0] p_addr = '0, p_wdata = '0;
    logic        p_we = 1'b0;
    int unsigned stab_err = 0;
    int unsigned req_seen = 0;
    logic [15:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end else begin
                rd_addr_q.push_back(mem_addr);
            end
            completed = 1'b1;
            need_new  = 1'b1;
        end
        if (req8 && ack8 && we8) mem8[addr8] = wdata8;
    end

    always @(negedge clk) begin
        if (mem_req) begin
            req_seen++;
            if (prev_req && !completed &&
                (mem_addr !== p_addr || mem_we !== p_we || (mem_we && mem_wdata !== p_wdata)))
                stab_err++;
            if (need_new) begin
                wait_cnt = (max_wait == 0) ? 0 : $urandom_range(max_wait, 0);
                need_new = 1'b0;
            end
            if (wait_cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                wait_cnt--;
            end
        end else begin
            mem_ack  = 1'b0;
            need_new = 1'b1;
        end
        prev_req  = mem_req;
        p_addr    = mem_addr;
        p_we      = mem_we;
        p_wdata   = mem_wdata;
        completed = 1'b0;
        ack8      = req8;
        rdata8    = mem8[addr8];
    end

    // ---------------- instruction-level reference model ----------------
    logic [15:0] m_acc, m_pc;
    logic [3:0]  m_flags;
    bit          m_halt, m_ill;
    logic [15:0] m_wa[$], m_wd[$];

    function automatic int sgn(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    task automatic model_run();
        int unsigned a = 0, p = RPC, w, arg, mode, opc, ea, b, steps = 0;
        int u = 0, s = 0, bin;
        bit fv = 0, fz = 0, fn = 0, fc = 0, done = 0, take;
        m_wa.delete(); m_wd.delete(); m_ill = 0;
        while (!done && steps < 10000) begin
            steps++;
            w   = rmem[p] & 32'hFF;  p = (p + 1) & 32'hFFFF;
            arg = rmem[p];           p = (p + 1) & 32'hFFFF;
            mode = w >> 6;
            opc  = w & 32'h3F;
            ea   = (mode == 2) ? ((p + arg) & 32'hFFFF) : arg;
            if (opc == 32'h3F) begin
                done = 1;
            end else if (!(opc inside {1, 2, 4, 5, 6, 7, 8, 9, 10, 11}) || mode == 3 ||
                         (opc == 2 && mode == 0)) begin
                done = 1; m_ill = 1;
            end else if (opc inside {4, 5, 6, 7}) begin
                take = (opc == 4) || (opc == 5 && fz) || (opc == 6 && fc) || (opc == 7 && fn);
                if (take) p = ea;
            end else if (opc == 2) begin
                rmem[ea] = 16'(a);
                m_wa.push_back(16'(ea));
                m_wd.push_back(16'(a));
            end else begin
                b = (mode == 0) ? arg : rmem[ea];
                if (opc == 1) begin
                    a = b;
                end else begin
                    if (opc == 8 || opc == 9) begin
                        bin = (opc == 9 && fc) ? 1 : 0;
                        u = int'(a) + int'(b) + bin;
                        s = sgn(a) + sgn(b) + bin;
                        fc = (u > 65535);
                    end else begin
                        bin = (opc == 11) ? 0 : (fc ? 0 : 1);
                        u = int'(a) - int'(b) - bin;
                        s = sgn(a) - sgn(b) - bin;
                        fc = (u >= 0);
                    end
                    fv = (s > 32767) || (s < -32768);
                    a  = int'(u) & 32'hFFFF;
                end
                fz = (a == 0);
                fn = (a >= 32768);
            end
        end
        m_halt  = done;
        m_acc   = 16'(a);
        m_pc    = 16'(p);
        m_flags = {fv, fz, fn, fc};
    endtask

    // ---------------- helpers ----------------
    task automatic clear_mem();
        for (int unsigned i = 0; i < 65536; i++) mem[i] = '0;
    endtask

    task automatic put(input int unsigned addr, input int unsigned op, input int unsigned arg);
        mem[addr & 32'hFFFF]       = 16'(op);
        mem[(addr + 1) & 32'hFFFF] = 16'(arg);
    endtask

    task automatic snapshot_model();
        for (int unsigned i = 0; i < 65536; i++) rmem[i] = mem[i];
        model_run();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        req_seen = 0;
        reset = 1'b1;
    endtask

    task automatic run_and_check(input string tag);
        int unsigned n = 0;
        snapshot_model();
        apply_reset();
        while (!halted && n < 20000) begin
            @(posedge clk); #1; n++;
        end
        check({tag, ".halted"}, halted, m_halt);
        check({tag, ".illegal"}, illegal, m_ill);
        check({tag, ".acc"}, acc, m_acc);
        check({tag, ".flags"}, flags, m_flags);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".nwr"}, wr_addr_q.size(), m_wa.size());
        for (int i = 0; i < m_wa.size() && i < wr_addr_q.size(); i++)
            check($sformatf("%s.wr%0d", tag, i), {wr_addr_q[i], wr_data_q[i]}, {m_wa[i], m_wd[i]});
    endtask

    task automatic gen_random();
        int unsigned alu_ops[5] = '{1, 8, 9, 10, 11};
        int unsigned a = RPC, n = $urandom_range(14, 4), k, mode, op, arg, dat;
        clear_mem();
        for (int unsigned i = 0; i < 16; i++) mem[16'h0800 + i] = 16'($urandom);
        for (int unsigned i = 0; i < n; i++) begin
            k   = $urandom_range(9, 0);
            dat = 32'h800 + $urandom_range(15, 0);
            if (k <= 4) begin
                op   = alu_ops[$urandom_range(4, 0)];
                mode = $urandom_range(2, 0);
            end else if (k <= 6) begin
                op   = 2;
                mode = $urandom_range(2, 1);
            end else begin
                op   = 4 + $urandom_range(3, 0);
                mode = $urandom_range(2, 0);
            end
            if (op >= 4 && op <= 7)
                arg = (mode == 2) ? 2 : a + 4;
            else if (mode == 0)
                arg = $urandom;
            else if (mode == 1)
                arg = dat;
            else
                arg = (dat - (a + 2)) & 32'hFFFF;
            put(a, ($urandom_range(255, 0) << 8) | (mode << 6) | op, arg);
            a += 2;
        end
        k = $urandom_range(3, 0);
        case (k)
            0:       put(a, (32'($urandom_range(3, 0)) << 6) | 32'h3F, 0);
            1:       put(a, $urandom_range(32'h3E, 32'h0C), 0);
            2:       put(a, 32'hC8, 1);
            default: put(a, 32'h02, 32'h800);
        endcase
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int unsigned n;
        bit found;

        clear_mem();
        put(16'h64, 32'h01, 5);
        put(16'h66, 32'h0B, 5);
        put(16'h68, 32'h05, 16'h70);
        put(16'h70, 32'h3F, 0);
        snapshot_model();
        for (int unsigned i = 0; i < 256; i++) mem8[i] = '0;
        mem8[0] = 8'h01; mem8[1] = 8'h7F;
        mem8[2] = 8'h08; mem8[3] = 8'h01;
        mem8[4] = 8'h09; mem8[5] = 8'hFF;
        mem8[6] = 8'h3F; mem8[7] = 8'h00;
        max_wait = 0;

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.acc", acc, 0);
        check("rst.flags", flags, 0);
        check("rst.halted", halted, 0);
        check("rst.illegal", illegal, 0);
        check("rst.req", mem_req, 0);
        check("rst.pc", pc, RPC);
        reset = 1'b1;
        @(posedge clk); #1;
        check("first.req", mem_req, 1);
        check("first.addr", mem_addr, 16'h0064);
        check("first.we", mem_we, 0);
        n = 0;
        while (!halted && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("jz.cycles", n, 8);
        check("jz.acc", acc, 0);
        check("jz.flags", flags, 4'b0101);
        check("jz.illegal", illegal, 0);
        check("jz.pc", pc, 16'h0072);
        check("jz.model_acc", acc, m_acc);
        check("jz.model_flags", flags, m_flags);

        // 8-bit overflow and carry-in behaviour
        @(negedge clk); run8 = 1'b1;
        n = 0;
        while (!(req8 && addr8 == 8'h04) && n < 50) begin
            @(negedge clk); n++;
        end
        check("w8.reach", n < 50, 1);
        check("w8.add_acc", acc8, 8'h80);
        check("w8.add_flags", flags8, 4'b1010);
        n = 0;
        while (!halted8 && n < 50) begin
            @(negedge clk); n++;
        end
        check("w8.adc_acc", acc8, 8'h7F);
        check("w8.adc_flags", flags8, 4'b1001);
        check("w8.illegal", illegal8, 0);
        check("w8.pc", pc8, 8'h08);

        // single store with wait states
        clear_mem();
        put(16'h64, 32'h01, 16'h1234);
        put(16'h66, 32'h42, 16'h000A);
        put(16'h68, 32'h3F, 0);
        max_wait = 3;
        run_and_check("store");
        check("store.count", wr_addr_q.size(), 1);
        check("store.addr", wr_addr_q[0], 16'h000A);
        check("store.mem", mem[16'h000A], 16'h1234);
        check("store.pc", pc, 16'h006A);
        check("store.flags", flags, 4'b0000);

        // PC-relative load
        clear_mem();
        put(16'h64, 32'h04, 16'h0100);
        put(16'h100, 32'h81, 16'h0004);
        put(16'h102, 32'h3F, 0);
        mem[16'h0106] = 16'hBEEF;
        max_wait = 1;
        run_and_check("off");
        found = 0;
        foreach (rd_addr_q[i]) if (rd_addr_q[i] == 16'h0106) found = 1;
        check("off.read_at_0106", found, 1);
        check("off.acc", acc, 16'hBEEF);

        // illegal opcode and REG mode trap
        for (int t = 0; t < 2; t++) begin
            clear_mem();
            put(16'h64, (t == 0) ? 32'h03 : 32'hC1, 5);
            max_wait = 0;
            run_and_check((t == 0) ? "ill_op" : "ill_reg");
            check("ill.halted", halted, 1);
            check("ill.flag", illegal, 1);
            req_seen = 0;
            repeat (20) @(negedge clk);
            check("ill.no_req", req_seen, 0);
        end

        // Fibonacci, count = 5
        clear_mem();
        put(16'h64, 32'h41, 16'h200); put(16'h66, 32'h48, 16'h201);
        put(16'h68, 32'h42, 16'h203); put(16'h6A, 32'h41, 16'h201);
        put(16'h6C, 32'h42, 16'h200); put(16'h6E, 32'h41, 16'h203);
        put(16'h70, 32'h42, 16'h201); put(16'h72, 32'h41, 16'h202);
        put(16'h74, 32'h0B, 1);       put(16'h76, 32'h42, 16'h202);
        put(16'h78, 32'h05, 16'h7C);  put(16'h7A, 32'h04, 16'h64);
        put(16'h7C, 32'h3F, 0);
        mem[16'h201] = 16'd1;
        mem[16'h202] = 16'd5;
        max_wait = 2;
        run_and_check("fib");
        check("fib.a", mem[16'h200], 16'd5);
        check("fib.b", mem[16'h201], 16'd8);
        check("fib.cnt", mem[16'h202], 16'd0);

        // reset in the middle of a write transfer
        max_wait = 3;
        apply_reset();
        n = 0;
        while (!(mem_req && mem_we) && n < 200) begin
            @(negedge clk); n++;
        end
        check("midwr.found", n < 200, 1);
        #2 reset = 1'b0;
        #1;
        check("midwr.req", mem_req, 0);
        check("midwr.we", mem_we, 0);
        check("midwr.pc", pc, RPC);
        @(negedge clk); reset = 1'b1;

        for (int t = 0; t < 12; t++) begin
            gen_random();
            max_wait = $urandom_range(3, 0);
            run_and_check($sformatf("rnd%0d", t));
        end

        check("req_stable", stab_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
